// File: rtl/ara_pkg.sv
// Shared types, default sizes and helpers for the Ara multi-queue sequencer.
// The ID type is sized from DefNrVInsn, so the sequencer's NrVInsn must keep that value.
package ara_pkg;

    localparam int unsigned DefNrVInsn  = 8;
    localparam int unsigned DefNrPEs    = 8;
    localparam int unsigned DefNrVRegs  = 32;
    localparam int unsigned DefAckDepth = 2;

    localparam int unsigned IdW   = $clog2(DefNrVInsn);
    localparam int unsigned VRegW = $clog2(DefNrVRegs);

    typedef logic [IdW-1:0] vid_t;

    typedef struct packed {
        vid_t vid;
        logic valid;
    } vreg_access_t;

    localparam logic [VRegW-1:0] VMASK = VRegW'(0);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_e;

    function automatic logic [DefNrVInsn-1:0] vid_onehot(input vid_t id);
        logic [DefNrVInsn-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Leading-zero style search from the LSB: lowest index whose busy bit is clear.
    function automatic vid_t lowest_free(input logic [DefNrVInsn-1:0] busy);
        vid_t id;
        id = '0;
        for (int i = DefNrVInsn - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                id = vid_t'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    // A list entry only produces a hazard while the instruction it names is still busy.
    function automatic logic [DefNrVInsn-1:0] entry_hit(input vreg_access_t e,
                                                        input logic [DefNrVInsn-1:0] busy);
        return (e.valid && busy[e.vid]) ? vid_onehot(e.vid) : '0;
    endfunction

endpackage

// File: rtl/ara_sequencer_mq_ack_fifo.sv
// ara_seq_ack_fifo: in-order queue of instruction IDs awaiting acknowledgment.
// Accepts a push while full when a pop happens in the same cycle.
module ara_seq_ack_fifo
    import ara_pkg::*;
#(
    parameter int unsigned Depth = DefAckDepth
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  vid_t data_i,
    input  logic pop_i,
    output vid_t data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    vid_t            mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push_s, do_pop_s;

    assign empty_o   = (cnt_q == CntW'(0));
    assign full_o    = (cnt_q == CntW'(Depth));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = mem_q[rd_ptr_q];

    // storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? PtrW'(0) : wr_ptr_q + PtrW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? PtrW'(0) : rd_ptr_q + PtrW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ara_sequencer_mq.sv
// ara_sequencer_mq: ID allocation, PE run tracking, RAW/WAR/WAW hazard vectors and an
// in-order acknowledgment queue. Macro ARA_SEQ_STATS_EN adds a saturating stall counter.
module ara_sequencer_mq
    import ara_pkg::*;
#(
    parameter int unsigned NrVInsn  = DefNrVInsn,
    parameter int unsigned NrPEs    = DefNrPEs,
    parameter int unsigned NrVRegs  = DefNrVRegs,
    parameter int unsigned AckDepth = DefAckDepth
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [$clog2(NrVRegs)-1:0]        req_vs1_i,
    input  logic [$clog2(NrVRegs)-1:0]        req_vs2_i,
    input  logic [$clog2(NrVRegs)-1:0]        req_vd_i,
    input  logic                              req_use_vs1_i,
    input  logic                              req_use_vs2_i,
    input  logic                              req_use_vd_i,
    input  logic                              req_vm_i,
    input  logic [NrPEs-1:0]                  req_pe_mask_i,
    input  logic                              req_needs_ack_i,
    output logic                              issue_valid_o,
    input  logic [NrPEs-1:0]                  issue_ready_i,
    output logic [$clog2(NrVInsn)-1:0]        issue_id_o,
    output logic [NrVInsn-1:0]                issue_hazard_vs1_o,
    output logic [NrVInsn-1:0]                issue_hazard_vs2_o,
    output logic [NrVInsn-1:0]                issue_hazard_vd_o,
    output logic [NrVInsn-1:0]                issue_hazard_vm_o,
    output logic [NrVInsn-1:0]                issue_running_o,
    input  logic [NrPEs-1:0][NrVInsn-1:0]     pe_done_i,
    input  logic                              ack_valid_i,
    input  logic                              ack_error_i,
    output logic                              resp_valid_o,
    output logic [$clog2(NrVInsn)-1:0]        resp_id_o,
    output logic                              resp_error_o,
    output logic                              idle_o,
    output logic [31:0]                       stall_cnt_o
);
    localparam int unsigned RegW = $clog2(NrVRegs);

    seq_state_e                 state_q, state_d;
    logic                       hold_s, slot_free_s, all_ready_s;
    logic [NrPEs-1:0][NrVInsn-1:0] running_q, running_d, running_clr_s;
    logic [NrVInsn-1:0]         inq_q, inq_d;
    vreg_access_t               wr_list_q [NrVRegs];
    vreg_access_t               wr_list_d [NrVRegs];
    vreg_access_t               rd_list_q [NrVRegs];
    vreg_access_t               rd_list_d [NrVRegs];

    logic [NrVInsn-1:0]         run_any_q_s, run_any_clr_s, run_any_d_s;
    logic [NrVInsn-1:0]         busy_s, busy_hz_s, pop_oh_s, new_oh_s;
    logic [NrVInsn-1:0]         hz_vs1_s, hz_vs2_s, hz_vd_s, hz_vm_s, war_s;
    logic [NrPEs-1:0]           pe_set_s;
    vid_t                       next_id_s, fifo_head_s;
    logic                       full_s, ops_stall_s, accept_s, push_s, pop_s;
    logic                       fifo_full_s, fifo_empty_s;

    logic                       issue_valid_q;
    vid_t                       issue_id_q;
    logic [NrVInsn-1:0]         hz_vs1_q, hz_vs2_q, hz_vd_q, hz_vm_q, running_vec_q;
    logic                       resp_valid_q, resp_error_q, idle_q;
    vid_t                       resp_id_q;

    assign all_ready_s = &issue_ready_i;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pending issue that is not taken this cycle freezes the slot
    always_comb begin
        state_d     = state_q;
        hold_s      = 1'b0;
        slot_free_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid_q && !all_ready_s) begin
                    state_d = HOLD;
                    hold_s  = 1'b1;
                end else begin
                    slot_free_s = 1'b1;
                end
            end
            HOLD: begin
                if (all_ready_s) begin
                    state_d     = IDLE;
                    slot_free_s = 1'b1;
                end else begin
                    hold_s = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy views: registered for allocation, post-done/post-pop for hazards
    always_comb begin
        running_clr_s = running_q & ~pe_done_i;
        run_any_q_s   = '0;
        run_any_clr_s = '0;
        for (int p = 0; p < NrPEs; p++) begin
            run_any_q_s   = run_any_q_s | running_q[p];
            run_any_clr_s = run_any_clr_s | running_clr_s[p];
        end
        busy_s    = run_any_q_s | inq_q;
        pop_oh_s  = pop_s ? vid_onehot(fifo_head_s) : '0;
        busy_hz_s = run_any_clr_s | (inq_q & ~pop_oh_s);
    end

    assign next_id_s = lowest_free(busy_s);

    // WAR on vd is folded into every source vector
    assign war_s    = req_use_vd_i  ? entry_hit(rd_list_q[req_vd_i], busy_hz_s) : '0;
    assign hz_vs1_s = (req_use_vs1_i ? entry_hit(wr_list_q[req_vs1_i], busy_hz_s) : '0) | war_s;
    assign hz_vs2_s = (req_use_vs2_i ? entry_hit(wr_list_q[req_vs2_i], busy_hz_s) : '0) | war_s;
    assign hz_vm_s  = (!req_vm_i ? entry_hit(wr_list_q[VMASK], busy_hz_s) : '0) | war_s;
    assign hz_vd_s  = req_use_vd_i  ? entry_hit(wr_list_q[req_vd_i], busy_hz_s) : '0;

    assign ops_stall_s = !req_use_vs1_i && !req_use_vs2_i && req_vm_i &&
                         (|(hz_vs1_s | hz_vs2_s | hz_vd_s | hz_vm_s));
    assign full_s      = (&busy_s) || (req_needs_ack_i && fifo_full_s);
    assign accept_s    = req_valid_i && slot_free_s && !full_s && !ops_stall_s;
    assign push_s      = accept_s && req_needs_ack_i;
    assign pop_s       = ack_valid_i && !fifo_empty_s;
    assign req_ready_o = accept_s;

    // next-state running set, ack membership and access lists
    always_comb begin
        pe_set_s             = req_pe_mask_i;
        pe_set_s[NrPEs-1]    = req_pe_mask_i[NrPEs-1] | ~req_vm_i;
        new_oh_s             = accept_s ? vid_onehot(next_id_s) : '0;
        running_d            = running_clr_s;
        run_any_d_s          = '0;
        for (int p = 0; p < NrPEs; p++) begin
            running_d[p] = running_clr_s[p] | (pe_set_s[p] ? new_oh_s : '0);
            run_any_d_s  = run_any_d_s | running_d[p];
        end
        inq_d     = (inq_q & ~pop_oh_s) | (push_s ? new_oh_s : '0);
        wr_list_d = wr_list_q;
        rd_list_d = rd_list_q;
        // entries naming the reallocated ID are stale and get dropped
        for (int r = 0; r < NrVRegs; r++) begin
            if (accept_s && req_use_vd_i && (req_vd_i == RegW'(r))) begin
                wr_list_d[r] = '{vid: next_id_s, valid: 1'b1};
            end else if (accept_s && (wr_list_q[r].vid == next_id_s)) begin
                wr_list_d[r].valid = 1'b0;
            end else begin
                wr_list_d[r] = wr_list_q[r];
            end
            if (accept_s && ((req_use_vs1_i && (req_vs1_i == RegW'(r))) ||
                             (req_use_vs2_i && (req_vs2_i == RegW'(r))) ||
                             (!req_vm_i && (VMASK == RegW'(r))))) begin
                rd_list_d[r] = '{vid: next_id_s, valid: 1'b1};
            end else if (accept_s && (rd_list_q[r].vid == next_id_s)) begin
                rd_list_d[r].valid = 1'b0;
            end else begin
                rd_list_d[r] = rd_list_q[r];
            end
        end
    end

    // tracking state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running_q <= '0;
            inq_q     <= '0;
            for (int r = 0; r < NrVRegs; r++) begin
                wr_list_q[r] <= '0;
                rd_list_q[r] <= '0;
            end
        end else begin
            running_q <= running_d;
            inq_q     <= inq_d;
            for (int r = 0; r < NrVRegs; r++) begin
                wr_list_q[r] <= wr_list_d[r];
                rd_list_q[r] <= rd_list_d[r];
            end
        end
    end

    // registered PE request; held hazards shrink as producers retire
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_valid_q <= 1'b0;
            issue_id_q    <= '0;
            hz_vs1_q      <= '0;
            hz_vs2_q      <= '0;
            hz_vd_q       <= '0;
            hz_vm_q       <= '0;
        end else if (accept_s) begin
            issue_valid_q <= 1'b1;
            issue_id_q    <= next_id_s;
            hz_vs1_q      <= hz_vs1_s;
            hz_vs2_q      <= hz_vs2_s;
            hz_vd_q       <= hz_vd_s;
            hz_vm_q       <= hz_vm_s;
        end else if (hold_s) begin
            hz_vs1_q      <= hz_vs1_q & run_any_d_s;
            hz_vs2_q      <= hz_vs2_q & run_any_d_s;
            hz_vd_q       <= hz_vd_q & run_any_d_s;
            hz_vm_q       <= hz_vm_q & run_any_d_s;
        end else begin
            issue_valid_q <= 1'b0;
        end
    end

    // response pulse and status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_error_q  <= 1'b0;
            running_vec_q <= '0;
            idle_q        <= 1'b1;
        end else begin
            resp_valid_q  <= pop_s;
            if (pop_s) begin
                resp_id_q    <= fifo_head_s;
                resp_error_q <= ack_error_i;
            end
            running_vec_q <= run_any_d_s;
            idle_q        <= ~|(run_any_d_s | inq_d);
        end
    end

    ara_seq_ack_fifo #(
        .Depth (AckDepth)
    ) i_ack_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_s),
        .data_i  (next_id_s),
        .pop_i   (pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

`ifdef ARA_SEQ_STATS_EN
    logic [31:0] stall_cnt_q;

    // saturating count of cycles a valid request is refused
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
        end else if (req_valid_i && !accept_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

    assign issue_valid_o      = issue_valid_q;
    assign issue_id_o         = issue_id_q;
    assign issue_hazard_vs1_o = hz_vs1_q;
    assign issue_hazard_vs2_o = hz_vs2_q;
    assign issue_hazard_vd_o  = hz_vd_q;
    assign issue_hazard_vm_o  = hz_vm_q;
    assign issue_running_o    = running_vec_q;
    assign resp_valid_o       = resp_valid_q;
    assign resp_id_o          = resp_id_q;
    assign resp_error_o       = resp_error_q;
    assign idle_o             = idle_q;

endmodule

// File: tb/tb_ara_sequencer_mq.sv
// Directed bench for ara_sequencer_mq with hand-computed expectations.
module tb_ara_sequencer_mq;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid, req_ready;
    logic [4:0]        req_vs1, req_vs2, req_vd;
    logic              req_use_vs1, req_use_vs2, req_use_vd, req_vm, req_needs_ack;
    logic [7:0]        req_pe_mask;
    logic              issue_valid;
    logic [7:0]        issue_ready;
    logic [2:0]        issue_id;
    logic [7:0]        hz_vs1, hz_vs2, hz_vd, hz_vm, issue_running;
    logic [7:0][7:0]   pe_done;
    logic              ack_valid, ack_error;
    logic              resp_valid, resp_error, idle;
    logic [2:0]        resp_id;
    logic [31:0]       stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ARA_SEQ_STATS_EN
    localparam logic [31:0] StallExp = 32'd5;
`else
    localparam logic [31:0] StallExp = 32'd0;
`endif

    always #5 clk_i = ~clk_i;

    ara_sequencer_mq dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_vs1_i          (req_vs1),
        .req_vs2_i          (req_vs2),
        .req_vd_i           (req_vd),
        .req_use_vs1_i      (req_use_vs1),
        .req_use_vs2_i      (req_use_vs2),
        .req_use_vd_i       (req_use_vd),
        .req_vm_i           (req_vm),
        .req_pe_mask_i      (req_pe_mask),
        .req_needs_ack_i    (req_needs_ack),
        .issue_valid_o      (issue_valid),
        .issue_ready_i      (issue_ready),
        .issue_id_o         (issue_id),
        .issue_hazard_vs1_o (hz_vs1),
        .issue_hazard_vs2_o (hz_vs2),
        .issue_hazard_vd_o  (hz_vd),
        .issue_hazard_vm_o  (hz_vm),
        .issue_running_o    (issue_running),
        .pe_done_i          (pe_done),
        .ack_valid_i        (ack_valid),
        .ack_error_i        (ack_error),
        .resp_valid_o       (resp_valid),
        .resp_id_o          (resp_id),
        .resp_error_o       (resp_error),
        .idle_o             (idle),
        .stall_cnt_o        (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                           input logic u1, input logic u2, input logic ud, input logic vm,
                           input logic [7:0] pe, input logic needs_ack);
        req_valid     = 1'b1;
        req_vs1       = vs1;
        req_vs2       = vs2;
        req_vd        = vd;
        req_use_vs1   = u1;
        req_use_vs2   = u2;
        req_use_vd    = ud;
        req_vm        = vm;
        req_pe_mask   = pe;
        req_needs_ack = needs_ack;
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_valid   = 1'b0;
        set_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        req_valid   = 1'b0;
        issue_ready = 8'h00;
        pe_done     = '0;
        ack_valid   = 1'b0;
        ack_error   = 1'b0;
        tick();
        tick();
        check_eq("rst_issue_valid", {63'd0, issue_valid}, 64'd0);
        check_eq("rst_idle", {63'd0, idle}, 64'd1);
        check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("rst_running", {56'd0, issue_running}, 64'd0);
        check_eq("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // single unmasked VADD v3 <- v1, v2 on PEs 0..3
        issue_ready = 8'hFF;
        set_req(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
        #1 check_eq("t1_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t1_issue_valid", {63'd0, issue_valid}, 64'd1);
        check_eq("t1_issue_id", {61'd0, issue_id}, 64'd0);
        check_eq("t1_hazards", {32'd0, hz_vs1, hz_vs2, hz_vd, hz_vm}, 64'd0);
        check_eq("t1_running", {56'd0, issue_running}, 64'h01);
        check_eq("t1_busy_idle", {63'd0, idle}, 64'd0);
        for (int p = 0; p < 4; p++) pe_done[p][0] = 1'b1;
        tick();
        pe_done = '0;
        check_eq("t1_done_idle", {63'd0, idle}, 64'd1);
        check_eq("t1_done_valid", {63'd0, issue_valid}, 64'd0);

        // held issue keeps a pending request refused for five cycles
        issue_ready = 8'h00;
        set_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
        #1 check_eq("st_accept", {63'd0, req_ready}, 64'd1);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1 check_eq("st_hold_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        req_valid = 1'b0;
        check_eq("st_stall_cnt", {32'd0, stall_cnt}, {32'd0, StallExp});
        check_eq("st_hold_valid", {63'd0, issue_valid}, 64'd1);
        issue_ready = 8'hFF;
        tick();
        pe_done[2][0] = 1'b1;
        tick();
        pe_done = '0;
        check_eq("st_idle", {63'd0, idle}, 64'd1);

        // RAW on v4, then held hazard clears once the writer retires
        set_req(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        #1 check_eq("t2_a_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t2_a_id", {61'd0, issue_id}, 64'd0);
        tick();
        issue_ready = 8'h7F;
        set_req(5'd4, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
        #1 check_eq("t2_b_ready", {63'd0, req_ready}, 64'd1);
        tick();
        check_eq("t2_b_id", {61'd0, issue_id}, 64'd1);
        check_eq("t2_b_hazards", {32'd0, hz_vs1, hz_vs2, hz_vd, hz_vm}, 64'h0100_0000);
        set_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        #1 check_eq("t2_hold_ready", {63'd0, req_ready}, 64'd0);
        pe_done[0][0] = 1'b1;
        tick();
        pe_done   = '0;
        req_valid = 1'b0;
        check_eq("t2_held_vs1", {56'd0, hz_vs1}, 64'h00);
        check_eq("t2_held_valid", {63'd0, issue_valid}, 64'd1);
        check_eq("t2_held_id", {61'd0, issue_id}, 64'd1);
        issue_ready = 8'hFF;
        tick();
        check_eq("t2_taken", {63'd0, issue_valid}, 64'd0);
        pe_done[0][1] = 1'b1;
        tick();
        pe_done = '0;
        check_eq("t2_idle", {63'd0, idle}, 64'd1);

        // exhaust all eight IDs, then a freed ID is reused
        set_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 8; i++) begin
            #1 check_eq("t3_ready", {63'd0, req_ready}, 64'd1);
            tick();
            check_eq("t3_id", {61'd0, issue_id}, 64'(i));
        end
        #1 check_eq("t3_full_ready", {63'd0, req_ready}, 64'd0);
        pe_done[1][5] = 1'b1;
        tick();
        pe_done = '0;
        #1 check_eq("t3_reuse_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t3_reuse_id", {61'd0, issue_id}, 64'd5);
        pe_done[1] = 8'hFF;
        tick();
        pe_done = '0;
        check_eq("t3_idle", {63'd0, idle}, 64'd1);

        // ack queue depth 2: third ack-needing request waits for a pop
        set_req(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
        #1 check_eq("t4_l1_ready", {63'd0, req_ready}, 64'd1);
        tick();
        check_eq("t4_l1_id", {61'd0, issue_id}, 64'd0);
        set_req(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
        #1 check_eq("t4_l2_ready", {63'd0, req_ready}, 64'd1);
        tick();
        check_eq("t4_l2_id", {61'd0, issue_id}, 64'd1);
        set_req(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1);
        ack_valid = 1'b1;
        ack_error = 1'b1;
        #1 check_eq("t4_l3_stall", {63'd0, req_ready}, 64'd0);
        tick();
        ack_valid = 1'b0;
        ack_error = 1'b0;
        check_eq("t4_resp_valid", {63'd0, resp_valid}, 64'd1);
        check_eq("t4_resp_id", {61'd0, resp_id}, 64'd0);
        check_eq("t4_resp_error", {63'd0, resp_error}, 64'd1);
        #1 check_eq("t4_l3_ready", {63'd0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t4_l3_id", {61'd0, issue_id}, 64'd2);
        check_eq("t4_resp_pulse", {63'd0, resp_valid}, 64'd0);

        // drain the queue, then an ack on the empty queue is ignored
        ack_valid = 1'b1;
        tick();
        check_eq("t5_resp1_valid", {63'd0, resp_valid}, 64'd1);
        check_eq("t5_resp1", {60'd0, resp_id, resp_error}, {60'd0, 3'd1, 1'b0});
        tick();
        check_eq("t5_resp2", {60'd0, resp_id, resp_valid}, {60'd0, 3'd2, 1'b1});
        pe_done[0] = 8'hFF;
        tick();
        pe_done = '0;
        check_eq("t5_empty_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("t5_empty_id", {61'd0, resp_id}, 64'd2);
        check_eq("t5_idle", {63'd0, idle}, 64'd1);
        tick();
        ack_valid = 1'b0;
        check_eq("t5_empty_valid2", {63'd0, resp_valid}, 64'd0);
        check_eq("t5_idle2", {63'd0, idle}, 64'd1);
        check_eq("t5_running", {56'd0, issue_running}, 64'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ara_sequencer_mq.md
Name: ara_sequencer_mq

Overview:
- Next-generation Ara sequencer core. It allocates vector-instruction IDs, tracks which PEs are running each ID, and computes RAW/WAR/WAW hazard vectors per vector register.
- It issues registered PE requests and holds each one until all PEs accept it.
- New behaviour: a non-blocking in-order acknowledgment queue of depth AckDepth. Up to AckDepth loads, stores or scalar-result instructions may await acknowledgment without stalling issue.
- It sits between the dispatcher and the lanes/VLSU/slide/mask units.

Parameters:
- NrVInsn, 8, number of in-flight instruction IDs (power of 2, ≥2).
- NrPEs, 8, number of processing elements.
- NrVRegs, 32, number of architectural vector registers; v0 is the mask register.
- AckDepth, 2, acknowledgment queue depth (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  dispatcher request valid
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
- req_vs1_i / req_vs2_i / req_vd_i  in  $clog2(NrVRegs) each  register indices
- req_use_vs1_i / req_use_vs2_i / req_use_vd_i  in  1 each  operand-use flags
- req_vm_i  in  1  1 = unmasked; 0 = reads v0 and also runs on the mask PE
- req_pe_mask_i  in  NrPEs  PEs that will execute the instruction
- req_needs_ack_i  in  1  instruction requires an acknowledgment
- issue_valid_o  out  1  registered PE request valid
- issue_ready_i  in  NrPEs  per-PE ready; the request is taken when all bits are 1
- issue_id_o  out  $clog2(NrVInsn)  allocated ID
- issue_hazard_vs1_o / _vs2_o / _vd_o / _vm_o  out  NrVInsn each  hazard vectors
- issue_running_o  out  NrVInsn  running set (next-state view)
- pe_done_i  in  NrPEs×NrVInsn  per-PE done pulses
- ack_valid_i  in  1  acknowledgment for the oldest queued ID
- ack_error_i  in  1  error flag qualifying ack_valid_i
- resp_valid_o  out  1  response pulse
- resp_id_o  out  $clog2(NrVInsn)  acknowledged ID
- resp_error_o  out  1  error returned with the response
- idle_o  out  1  no ID running or awaiting acknowledgment
- stall_cnt_o  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0 except idle_o=1; running set, read/write lists, ack queue and counters cleared. Reset mid-operation drops every in-flight ID; no responses are emitted for them.
- ID busy = (running on any PE) OR (present in the ack queue). next_id = lowest free ID.
- full = all IDs busy, OR (req_needs_ack_i AND ack queue holds AckDepth entries).
- States: IDLE and HOLD.
  - IDLE: a request is accepted when req_valid_i && !full && no held request. Accept pulses req_ready_o combinationally the same cycle. issue_valid_o rises the next cycle.
  - IDLE → HOLD: issue_valid_o=1 and &issue_ready_i=0.
  - In HOLD: request fields are frozen; hazard vectors are ANDed every cycle with the next-state running set; req_ready_o=0.
  - HOLD → IDLE: the cycle &issue_ready_i=1. issue_valid_o drops the next cycle unless a new request is accepted in that same cycle (back-to-back issue is allowed).
- Hazards are computed on the lists after this cycle's done-clearing:
  - RAW: writer(vs1/vs2) into hazard_vs1/vs2; writer(v0) into hazard_vm when !req_vm_i.
  - WAR: reader(vd) into vs1, vs2 and vm.
  - WAW: writer(vd) into hazard_vd.
  - A list entry is valid only while its ID is busy.
- A request with no operands (no vs1, vs2 or v0 use) is stalled while any hazard bit is set. req_ready_o stays 0.
- On accept:
  - Set running[pe][id] for each bit of req_pe_mask_i, plus mask PE NrPEs-1 when !req_vm_i.
  - Update the write list for vd and the read lists for vs1, vs2 and v0; a later instruction overwrites an earlier entry.
  - Push id to the ack queue if req_needs_ack_i.
- pe_done_i clears running bits in the cycle it is sampled. A done bit for a non-running ID is ignored.
- Acknowledgments:
  - ack_valid_i pops the queue head. The next cycle gives resp_valid_o=1, resp_id_o=head, resp_error_o=ack_error_i.
  - ack_valid_i on an empty queue is ignored.
  - Push and pop in the same cycle are allowed when the queue is full.
- An ID freed by done/ack in cycle N is allocatable in cycle N+1.

Optional Feature:
- Macro: ARA_SEQ_STATS_EN.
- Defined: stall_cnt_o is a 32-bit saturating counter. It increments each cycle req_valid_i=1 and req_ready_o=0, and clears on reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are generated.

Decomposition:
- ara_pkg holds:
  - vid_t sized from NrVInsn;
  - vreg_access_t {vid, valid};
  - VMASK constant = 0;
  - seq_state_e {IDLE, HOLD}.
- Sub-module ara_seq_ack_fifo: AckDepth-deep ID FIFO with push, pop, full and empty.
- ID allocation uses the existing lzc.

Test Plan:
- Reset, then a single unmasked VADD v3←v1,v2 with pe_mask=0x0F and all ready → issue_id_o=0, all hazards 0; after pe_done_i[0..3][0], idle_o=1.
- A writes v4 (id0), then B reads v4 → B hazard_vs1=0x01. Hold B with issue_ready_i=0x7F; pulse done for id0 → held hazard_vs1 becomes 0x00 next cycle.
- Issue 8 instructions with no done → 9th request: req_ready_o=0. Done for id5 → next accept gets id5.
- AckDepth=2: two loads needing ack issue back-to-back; a third ack request stalls. Ack with error=1 → resp_id_o=0, resp_error_o=1; third is accepted the next cycle.
- Ack on empty queue → resp_valid_o stays 0; state unchanged.
- With ARA_SEQ_STATS_EN: 5 stalled cycles → stall_cnt_o=5. Without the macro → stall_cnt_o=0.
